cbm2_bus_sched: RTL and testbench
=================================

// Module: cbm2_bus_sched
// PURPOSE
//  Schedules the shared system bus/SDRAM between video (VIC or CRTC), the 6509 CPU and the IPC co-processor.
//  Splits each CPU clock into phase 0 (video slot) and phase 1 (CPU/co-processor slot).
//  Drives phase, cpuCycle and vidCycle into the bus decoder, and issues one RAM request per slot.
//  Produces CPU and co-processor clock enables, plus RDY stalls for VIC bus-steal and co-processor ownership.
// PARAMETERS
//  CLK_DIV  32  clk_sys cycles per CPU cycle; even, >=8
//  REQ_OFS   1  clk_sys cycles from slot start to the ram_req pulse; must be < CLK_DIV/2-2
// PORTS
//  clk_sys    in   1  system clock; the only clock
//  reset      in   1  asynchronous, active-high reset
//  pause      in   1  freeze the schedule; honoured only at cnt==0
//  model      in   1  0=P (VIC video), 1=B (CRTC video)
//  vid_en     in   1  video fetch enabled (VIC/CRTC running)
//  vic_ba     in   1  VIC bus steal: VIC also takes the phase-1 slot; ignored when model=1
//  cop_req    in   1  co-processor bus request (level)
//  ram_ack    in   1  1-cycle pulse: SDRAM access complete, data valid
//  phase      out  1  0=first half, 1=second half of the CPU cycle
//  cpuCycle   out  1  CPU (or co-processor) owns the bus address/data
//  vidCycle   out  1  video owns the bus
//  ram_req    out  1  1-cycle pulse: start an SDRAM access
//  cpu_ce     out  1  1-cycle CPU clock enable
//  cpu_rdy    out  1  0 = CPU stalled (bus steal or co-processor owns the bus)
//  cop_gnt    out  1  co-processor owns phase-1 slots
//  cop_ce     out  1  1-cycle co-processor clock enable
//  overrun    out  1  sticky: a slot's ram_ack arrived late; cleared by reset only
// BEHAVIOUR
//  Reset (async): cnt=0, state IDLE, all outputs 0 except cpu_rdy=1.
//  Counter cnt: width $clog2(CLK_DIV).
//   - Increments modulo CLK_DIV each clk_sys.
//   - Holds at 0 while pause=1.
//   - Holds at CLK_DIV-1 while an access is pending (stretch).
//  phase = (cnt >= CLK_DIV/2); registered so it changes together with cnt.
//  FSM states:
//   - IDLE -> VID / CPU / COP at slot start + REQ_OFS; ram_req pulses in that transition cycle.
//   - VID / CPU / COP -> IDLE in the cycle after ram_ack.
//  Slot start is cnt==0 or cnt==CLK_DIV/2.
//  Owner selection:
//   - Phase 0: VID if vid_en, else no access.
//   - Phase 1, in priority order:
//     1. VID if !model & vic_ba & vid_en.
//     2. COP if cop_gnt.
//     3. Otherwise CPU.
//  vidCycle / cpuCycle:
//   - Asserted from slot start + REQ_OFS through the ack cycle inclusive.
//   - Never both high at once; 0 while IDLE.
//  cpu_ce: pulses at cnt==CLK_DIV-1, and only if a CPU access completed in this cycle.
//  cop_ce: same rule, for a COP access.
//  cpu_rdy:
//   - Updated at cnt==CLK_DIV-1 to !(next phase-1 owner is VID or COP).
//   - The next phase-1 owner is predicted from vic_ba / cop_gnt sampled at that edge.
//  Co-processor arbitration, evaluated at cnt==CLK_DIV-1 only:
//   - cop_req=1 & cop_gnt=0: cop_gnt<=1.
//   - cop_req=0 & cop_gnt=1: cop_gnt<=0.
//   - Handover never splits a CPU cycle.
//  Stretch:
//   - If no ram_ack has arrived for the current access when cnt==CLK_DIV-1, cnt holds.
//   - No *_ce fires until the ack arrives.
//   - overrun<=1 when that late ack arrives.
//  Pause at cnt==0: no request is issued; cpu_ce and cop_ce stay 0; outputs otherwise hold.
//  ram_ack while IDLE: ignored; no state change, no *_ce pulse.
//  model changing mid-cycle: takes effect at the next slot start.
//  Reset mid-access: immediate return to reset values; the next ram_ack is treated as stray.
// STRUCTURE
//  cbm2_pkg: typedef enum {IDLE, VID, CPU, COP} bus_owner_t; CLK_DIV-derived localparams HALF and LAST.
//  Sub-module cbm2_slot_timer: cnt, phase, and the slot-start / last-cycle strobes, with hold inputs.
//  This top: owner FSM, arbitration and the output registers.
// TESTING
//  Run with CLK_DIV=32 and REQ_OFS=1 unless a scenario says otherwise.
//  1. Free-run: model=1, vid_en=1, ram_ack 3 cycles after each req.
//     -> ram_req at cnt 1 and 17; vidCycle in cnt 1..4; cpuCycle in cnt 17..20; cpu_ce at cnt 31 every cycle.
//  2. vic_ba=1, model=0:
//     -> both slots have vidCycle; cpu_rdy=0 from the next cnt==31; cpu_ce never pulses.
//     vic_ba=0 -> cpu_rdy=1 one CPU cycle later.
//  3. cop_req raised at cnt 10:
//     -> cop_gnt=1 at cnt 31; next phase 1 has cpuCycle and cop_ce, with cpu_rdy=0.
//     Drop cop_req -> grant released at the next cnt==31.
//  4. ram_ack delayed 20 cycles on a CPU slot:
//     -> cnt holds at 31; cpu_ce fires only in the ack cycle; overrun=1 and stays 1.
//  5. pause=1 at cnt 5:
//     -> the cycle completes; cnt holds at 0 with no ram_req.
//     Release -> ram_req at cnt 1 of the next cycle.
//  6. Assert reset during a pending VID access:
//     -> all outputs 0, cpu_rdy=1, cnt=0 at once.
//     A stray ram_ack after release causes no state change.

Source files
------------

// File: rtl/cbm2_pkg.sv
// Shared types and timing constants for the CBM-II bus scheduler.
package cbm2_pkg;

    // Who currently owns the bus slot; IDLE means no access in flight.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        CPU  = 2'd2,
        COP  = 2'd3
    } bus_owner_t;

    localparam int DEF_CLK_DIV = 32;
    localparam int DEF_REQ_OFS = 1;
    localparam int HALF        = DEF_CLK_DIV / 2;
    localparam int LAST        = DEF_CLK_DIV - 1;

    // Slot boundary helpers for a given clk_sys-per-CPU-cycle divider.
    function automatic int half_of(input int div);
        return div / 2;
    endfunction

    function automatic int last_of(input int div);
        return div - 1;
    endfunction

endpackage

// File: rtl/cbm2_if.sv
// Bus scheduler signal bundle. The host/bench side uses the master modport,
// the scheduler uses the slave modport.
//
// Handshake: ram_req is a 1-cycle start pulse issued only when the scheduler
// has no access outstanding; exactly one ram_ack pulse completes it. An ack
// seen with no access outstanding is ignored. The access stays "valid"
// (vidCycle/cpuCycle high) from the req cycle through the ack cycle inclusive.
interface cbm2_if;
    logic                  pause;
    logic                  model;
    logic                  vid_en;
    logic                  vic_ba;
    logic                  cop_req;
    logic                  ram_ack;
    logic                  phase;
    logic                  cpuCycle;
    logic                  vidCycle;
    logic                  ram_req;
    logic                  cpu_ce;
    logic                  cpu_rdy;
    logic                  cop_gnt;
    logic                  cop_ce;
    logic                  overrun;
    logic [7:0]            cnt_dbg;
    cbm2_pkg::bus_owner_t  owner_dbg;

    modport master (
        output pause, model, vid_en, vic_ba, cop_req, ram_ack,
        input  phase, cpuCycle, vidCycle, ram_req, cpu_ce, cpu_rdy,
        input  cop_gnt, cop_ce, overrun, cnt_dbg, owner_dbg
    );

    modport slave (
        input  pause, model, vid_en, vic_ba, cop_req, ram_ack,
        output phase, cpuCycle, vidCycle, ram_req, cpu_ce, cpu_rdy,
        output cop_gnt, cop_ce, overrun, cnt_dbg, owner_dbg
    );
endinterface

// File: rtl/cbm2_slot_timer.sv
// CPU-cycle position counter: splits each CPU cycle into two slots and
// provides the strobes the owner FSM keys off. Holds at 0 for pause and at
// the last count while an access is still outstanding.
module cbm2_slot_timer
    import cbm2_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int REQ_OFS = DEF_REQ_OFS
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pause_i,
    input  logic                       hold_last_i,
    output logic [$clog2(CLK_DIV)-1:0] cnt_o,
    output logic                       phase_o,
    output logic                       last_o,
    output logic                       adv_o,
    output logic                       slot_now_o,
    output logic                       req_next_o,
    output logic                       req_phase_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_C = CW'(half_of(CLK_DIV));
    localparam logic [CW-1:0] LAST_C = CW'(last_of(CLK_DIV));
    localparam logic [CW-1:0] REQ0_C = CW'(REQ_OFS);
    localparam logic [CW-1:0] REQ1_C = CW'(half_of(CLK_DIV) + REQ_OFS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q;
    logic          adv;

    // Next count: advance modulo CLK_DIV unless paused at 0 or stretched at the end.
    always_comb begin
        adv = 1'b1;
        if (cnt_q == '0 && pause_i) adv = 1'b0;
        if (cnt_q == LAST_C && hold_last_i) adv = 1'b0;
        cnt_d = cnt_q;
        if (adv) cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + CW'(1);
    end

    // Counter and phase move together so phase never lags the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= (cnt_d >= HALF_C);
        end
    end

    assign cnt_o       = cnt_q;
    assign phase_o     = phase_q;
    assign last_o      = (cnt_q == LAST_C);
    assign adv_o       = adv;
    assign slot_now_o  = (cnt_q == '0) || (cnt_q == HALF_C);
    assign req_next_o  = adv && ((cnt_d == REQ0_C) || (cnt_d == REQ1_C));
    assign req_phase_o = (cnt_d >= HALF_C);
endmodule

// File: rtl/cbm2_bus_sched.sv
// CBM-II shared bus scheduler: one video slot and one CPU/co-processor slot
// per CPU cycle, one RAM request per slot, clock enables and RDY stalls.
module cbm2_bus_sched
    import cbm2_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int REQ_OFS = DEF_REQ_OFS
) (
    input  logic  clk_sys,
    input  logic  reset,
    cbm2_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic          phase, last, adv, slot_now, req_next, req_phase, hold_last;
    bus_owner_t    state_q, state_d, done_q, done_d, next_owner;
    logic          model_q, model_d, cop_gnt_q, cop_gnt_d, cpu_rdy_q, cpu_rdy_d;
    logic          overrun_q, overrun_d, stretch_q, stretch_d, ram_req_q, ram_req_d;
    logic          vid_cyc_q, cpu_cyc_q, steal, acked;

    // Stretch the cycle while any access is still waiting for its ack.
    assign hold_last = (state_q != IDLE) && !bus.ram_ack;

    cbm2_slot_timer #(.CLK_DIV(CLK_DIV), .REQ_OFS(REQ_OFS)) u_timer (
        .clk_i       (clk_sys),
        .rst_i       (reset),
        .pause_i     (bus.pause),
        .hold_last_i (hold_last),
        .cnt_o       (cnt),
        .phase_o     (phase),
        .last_o      (last),
        .adv_o       (adv),
        .slot_now_o  (slot_now),
        .req_next_o  (req_next),
        .req_phase_o (req_phase)
    );

    // Owner FSM, completion tracking, co-processor arbitration and RDY prediction.
    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        model_d    = model_q;
        cop_gnt_d  = cop_gnt_q;
        cpu_rdy_d  = cpu_rdy_q;
        overrun_d  = overrun_q;
        stretch_d  = stretch_q;
        ram_req_d  = 1'b0;
        next_owner = IDLE;
        steal      = !model_q && bus.vic_ba && bus.vid_en;
        acked      = (state_q != IDLE) && bus.ram_ack;

        // A model change only counts from a slot boundary onwards.
        if (slot_now) model_d = bus.model;

        if (req_phase) next_owner = steal ? VID : (cop_gnt_q ? COP : CPU);
        else           next_owner = bus.vid_en ? VID : IDLE;

        if (acked) begin
            state_d = IDLE;
            if (state_q == CPU || state_q == COP) done_d = state_q;
            if (stretch_q) overrun_d = 1'b1;
        end

        if ((state_q == IDLE || acked) && req_next && next_owner != IDLE) begin
            state_d   = next_owner;
            ram_req_d = 1'b1;
        end

        if (last && !adv) stretch_d = 1'b1;

        // End of CPU cycle: grant handover and RDY for the coming phase 1.
        if (last && adv) begin
            stretch_d = 1'b0;
            done_d    = IDLE;
            if (bus.cop_req && !cop_gnt_q)      cop_gnt_d = 1'b1;
            else if (!bus.cop_req && cop_gnt_q) cop_gnt_d = 1'b0;
            cpu_rdy_d = !((!bus.model && bus.vic_ba && bus.vid_en) || cop_gnt_d);
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            done_q    <= IDLE;
            model_q   <= 1'b0;
            cop_gnt_q <= 1'b0;
            cpu_rdy_q <= 1'b1;
            overrun_q <= 1'b0;
            stretch_q <= 1'b0;
            ram_req_q <= 1'b0;
            vid_cyc_q <= 1'b0;
            cpu_cyc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            model_q   <= model_d;
            cop_gnt_q <= cop_gnt_d;
            cpu_rdy_q <= cpu_rdy_d;
            overrun_q <= overrun_d;
            stretch_q <= stretch_d;
            ram_req_q <= ram_req_d;
            vid_cyc_q <= (state_d == VID);
            cpu_cyc_q <= (state_d == CPU) || (state_d == COP);
        end
    end

    assign bus.phase     = phase;
    assign bus.vidCycle  = vid_cyc_q;
    assign bus.cpuCycle  = cpu_cyc_q;
    assign bus.ram_req   = ram_req_q;
    assign bus.cpu_rdy   = cpu_rdy_q;
    assign bus.cop_gnt   = cop_gnt_q;
    assign bus.overrun   = overrun_q;
    assign bus.cpu_ce    = last && ((done_q == CPU) || (state_q == CPU && bus.ram_ack));
    assign bus.cop_ce    = last && ((done_q == COP) || (state_q == COP && bus.ram_ack));
    assign bus.cnt_dbg   = 8'(cnt);
    assign bus.owner_dbg = state_q;
endmodule

// File: tb/tb_cbm2_bus_sched.sv
// Bench for cbm2_bus_sched: per-CPU-cycle plans (inputs, ack delays, pause)
// turned into expected slot intervals and pulse times.
module tb_cbm2_bus_sched;
    import cbm2_pkg::*;

    localparam int P_DIV  = 32;
    localparam int P_OFS  = 1;
    localparam int P_HALF = P_DIV / 2;
    localparam int P_LAST = P_DIV - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    cbm2_if bus();

    cbm2_bus_sched #(.CLK_DIV(P_DIV), .REQ_OFS(P_OFS)) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] exp_q[$];     // owners of the requests expected this CPU cycle
    bit         m_gnt = 1'b0;
    bit         m_rdy = 1'b1;
    bit         m_ovr = 1'b0;
    int         m_pref = 0;   // paused clocks at cnt 0 before the next cycle

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp_v);
        end
    endtask

    task automatic check_out(input int cnt_e, input bus_owner_t own, input bit req,
                             input bit cce, input bit oce);
        check_eq("cnt", bus.cnt_dbg, cnt_e);
        check_eq("phase", bus.phase, cnt_e >= P_HALF);
        check_eq("owner", bus.owner_dbg, own);
        check_eq("vidCycle", bus.vidCycle, own == VID);
        check_eq("cpuCycle", bus.cpuCycle, own == CPU || own == COP);
        check_eq("ram_req", bus.ram_req, req);
        check_eq("cpu_ce", bus.cpu_ce, cce);
        check_eq("cop_ce", bus.cop_ce, oce);
        check_eq("cop_gnt", bus.cop_gnt, m_gnt);
        check_eq("cpu_rdy", bus.cpu_rdy, m_rdy);
        check_eq("overrun", bus.overrun, m_ovr);
        if (bus.ram_req === 1'b1) begin
            if (exp_q.size() == 0) check_eq("req_extra", bus.ram_req, 1'b0);
            else                   check_eq("req_owner", bus.owner_dbg, exp_q.pop_front());
        end
    endtask

    // ---------------- driver: one CPU cycle ----------------
    // Entered just after a rising edge with the counter at 0.
    task automatic run_cycle(input bit mdl, input bit ven, input bit vba, input bit creq,
                             input int d0, input int d1, input bit stray,
                             input int p_next, input int abort_at);
        bus_owner_t own0, own1, own_e;
        bit         steal;
        int         a0, a1, len, cnt_e;
        steal = !mdl && vba && ven;
        own0  = ven ? VID : IDLE;
        own1  = steal ? VID : (m_gnt ? COP : CPU);
        a0    = P_OFS + d0;
        a1    = P_HALF + P_OFS + d1;
        len   = (a1 + 1 > P_DIV) ? a1 + 1 : P_DIV;
        bus.model   = mdl;
        bus.vid_en  = ven;
        bus.vic_ba  = vba;
        bus.cop_req = creq;
        for (int k = 0; k < m_pref; k++) begin
            bus.pause   = 1'b1;
            bus.ram_ack = stray && (k == 0);
            @(negedge clk);
            check_out(0, IDLE, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        if (own0 != IDLE) exp_q.push_back(own0);
        exp_q.push_back(own1);
        for (int t = 0; t < len; t++) begin
            bus.pause   = (p_next > 0) && (t >= 5);
            bus.ram_ack = (own0 != IDLE && t == a0) || (t == a1) || (stray && t == 0);
            cnt_e = (t < P_LAST) ? t : P_LAST;
            own_e = IDLE;
            if (own0 != IDLE && t >= P_OFS && t <= a0)  own_e = own0;
            else if (t >= P_HALF + P_OFS && t <= a1)    own_e = own1;
            @(negedge clk);
            check_out(cnt_e, own_e,
                      (t == P_OFS && own0 != IDLE) || (t == P_HALF + P_OFS),
                      (t == len - 1) && (own1 == CPU),
                      (t == len - 1) && (own1 == COP));
            if (t == abort_at) return;
            @(posedge clk); #1;
        end
        check_eq("req_left", exp_q.size(), 0);
        exp_q.delete();
        m_gnt = creq;
        m_rdy = !(steal || creq);
        if (a1 > P_LAST) m_ovr = 1'b1;
        m_pref = p_next;
        bus.ram_ack = 1'b0;
    endtask

    task automatic run_random();
        int r, d1;
        r = $urandom_range(0, 9);
        if (r == 0)      d1 = 14;
        else if (r == 1) d1 = $urandom_range(15, 22);
        else             d1 = $urandom_range(1, 8);
        run_cycle($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1), $urandom_range(1, 12), d1, $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0, -1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.pause = 0; bus.model = 0; bus.vid_en = 0; bus.vic_ba = 0;
        bus.cop_req = 0; bus.ram_ack = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_out(0, IDLE, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // free-running B model
        repeat (3) run_cycle(1, 1, 0, 0, 3, 3, 0, 0, -1);
        // VIC bus steal on and off
        repeat (2) run_cycle(0, 1, 1, 0, 3, 3, 0, 0, -1);
        repeat (2) run_cycle(0, 1, 0, 0, 3, 3, 0, 0, -1);
        // steal requested with video off, and a B-model steal request
        run_cycle(0, 0, 1, 0, 3, 3, 0, 0, -1);
        run_cycle(1, 1, 1, 0, 3, 3, 0, 0, -1);
        // co-processor grant and release
        repeat (2) run_cycle(1, 1, 0, 1, 3, 3, 0, 0, -1);
        repeat (2) run_cycle(1, 1, 0, 0, 3, 3, 1, 0, -1);
        // ack exactly at the last count, then a stretched CPU slot
        run_cycle(1, 1, 0, 0, 3, 14, 0, 0, -1);
        run_cycle(1, 1, 0, 0, 3, 20, 0, 0, -1);
        run_cycle(1, 1, 0, 0, 3, 3, 0, 0, -1);
        // pause raised mid-cycle, held over the next cnt 0
        run_cycle(1, 1, 0, 0, 3, 3, 0, 3, -1);
        run_cycle(1, 1, 0, 0, 3, 3, 1, 0, -1);

        repeat (40) run_random();

        // reset during a pending video access, then a stray ack
        run_cycle(1, 1, 0, 0, 6, 3, 0, 0, 2);
        #2 reset = 1'b1;
        m_gnt = 1'b0; m_rdy = 1'b1; m_ovr = 1'b0; m_pref = 0;
        exp_q.delete();
        #1 check_out(0, IDLE, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_cycle(1, 1, 0, 0, 3, 3, 1, 0, -1);

        repeat (3) run_random();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
